// File: rtl/keypad_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : keypad_scanner_if                                      |
// | Description : Pin and event bundle between the keypad scanner and    |
// |               its surroundings (matrix lines plus key-event outputs). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface keypad_scanner_if;
  logic [3:0] col_n;     // column sense from the matrix, active-low, asynchronous
  logic [3:0] row_n;     // row drive into the matrix, active-low, one-hot
  logic [3:0] gpi;       // key code {row, col}
  logic       dval;      // one-cycle key event strobe
  logic       gpi_hold;  // accepted key has been held long enough

  // Scanner side
  modport master (
    input  col_n,
    output row_n,
    output gpi,
    output dval,
    output gpi_hold
  );

  // Keypad / consumer side
  modport slave (
    output col_n,
    input  row_n,
    input  gpi,
    input  dval,
    input  gpi_hold
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : keypad_scanner                                         |
// | Description : 4x4 matrix keypad scanner with debounce, hold          |
// |               detection and optional autorepeat while holding.       |
// |               Optional feature macro: KEYPAD_AUTOREPEAT_EN           |
// |               (defined: dval repeats every REPEAT_CYC cycles in      |
// |               HOLD; undefined: no repeat logic is built).            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,  // cycles each row is driven
  parameter int DEBOUNCE_CYC = 8,   // stable cycles to accept press/release
  parameter int HOLD_CYC     = 64,  // cycles after acceptance to become a hold
  parameter int REPEAT_CYC   = 32   // autorepeat period while holding
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  keypad_scanner_if.master  bus
);

  // One shared counter serves every state; it is cleared on each state
  // change, so its width only has to cover the longest period.
  localparam int c_max_ab  = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int c_max_cd  = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int c_max_cnt = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_cnt_w   = $clog2(c_max_cnt + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEBOUNCE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYC - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [c_cnt_w-1:0] c_rep_last  = c_cnt_w'(REPEAT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_PRESSED  = 3'd2,
    ST_HOLD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [1:0]           r_row;        // current row; frozen while a key is captured
  logic [3:0]           r_row_n;      // registered one-hot-low row drive
  logic [1:0]           r_cand_col;   // captured candidate column
  logic [3:0]           r_gpi;
  logic                 r_dval;
  logic                 r_gpi_hold;
  logic [3:0]           r_col_meta;
  logic [3:0]           r_col_sync;

  logic                 w_any_low;
  logic [1:0]           w_low_col;
  logic                 w_cand_high;

  assign bus.row_n    = r_row_n;
  assign bus.gpi      = r_gpi;
  assign bus.dval     = r_dval;
  assign bus.gpi_hold = r_gpi_hold;

  // Two-flop synchronizer for the asynchronous column sense lines
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
    end else begin
      r_col_meta <= bus.col_n;
      r_col_sync <= r_col_meta;
    end
  end

  // Lowest-numbered low column wins when several keys share the row
  always_comb begin
    w_any_low = ~(&r_col_sync);
    casez (r_col_sync)
      4'b???0: w_low_col = 2'd0;
      4'b??01: w_low_col = 2'd1;
      4'b?011: w_low_col = 2'd2;
      4'b0111: w_low_col = 2'd3;
      default: w_low_col = 2'd0;
    endcase
    w_cand_high = r_col_sync[r_cand_col];
  end

  // Scan / debounce / hold / release sequencer with registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_SCAN;
      r_cnt      <= '0;
      r_row      <= 2'd0;
      r_row_n    <= 4'b1110;
      r_cand_col <= 2'd0;
      r_gpi      <= 4'h0;
      r_dval     <= 1'b0;
      r_gpi_hold <= 1'b0;
    end else begin
      r_dval <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_cnt == c_scan_last) begin
            r_cnt <= '0;
            if (w_any_low) begin
              // Row stays frozen on the captured key from here on
              r_cand_col <= w_low_col;
              r_state    <= ST_DEBOUNCE;
            end else begin
              r_row   <= r_row + 2'd1;
              r_row_n <= {r_row_n[2:0], r_row_n[3]};
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_DEBOUNCE: begin
          if (w_cand_high) begin
            // A bounce ends the dwell on this row as if it had timed out
            r_cnt   <= '0;
            r_state <= ST_SCAN;
            r_row   <= r_row + 2'd1;
            r_row_n <= {r_row_n[2:0], r_row_n[3]};
          end else if (r_cnt == c_deb_last) begin
            r_cnt      <= '0;
            r_gpi      <= {r_row, r_cand_col};
            r_dval     <= 1'b1;
            r_gpi_hold <= 1'b0;
            r_state    <= ST_PRESSED;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_PRESSED: begin
          if (w_cand_high) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end else if (r_cnt == c_hold_last) begin
            // Hold event: strobe again with gpi unchanged
            r_cnt      <= '0;
            r_gpi_hold <= 1'b1;
            r_dval     <= 1'b1;
            r_state    <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_HOLD: begin
          if (w_cand_high) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (r_cnt == c_rep_last) begin
            r_cnt  <= '0;
            r_dval <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
`endif
        end

        ST_RELEASE: begin
          if (!w_cand_high) begin
            // Any low sample restarts the release qualification
            r_cnt <= '0;
          end else if (r_cnt == c_deb_last) begin
            r_cnt      <= '0;
            r_gpi_hold <= 1'b0;
            r_row      <= r_row + 2'd1;
            r_row_n    <= {r_row_n[2:0], r_row_n[3]};
            r_state    <= ST_SCAN;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= ST_SCAN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_keypad_scanner                                      |
// | Description : Self-checking bench for keypad_scanner: a matrix model |
// |               drives the columns, a monitor records key events, and  |
// |               expectations come from the timing rules of the block.  |
// |               Optional feature macro: KEYPAD_AUTOREPEAT_EN           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_keypad_scanner;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 3;
  localparam int HOLD_CYC     = 20;
  localparam int REPEAT_CYC   = 8;

  typedef struct {
    logic [3:0] code;
    logic       hold;
    int         cyc;
    int         run;
  } ev_t;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] keys   = '0;     // pressed keys, index = row*4 + col
  logic [3:0]  col_w;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          tgt    = 0;
  int          run    = 0;
  logic        prev_dval = 1'b0;
  ev_t         evq[$];

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .REPEAT_CYC  (REPEAT_CYC)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Passive matrix: a column reads low when a pressed key sits on a driven row
  always_comb begin
    col_w = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (keys[rr*4+cc] && !bus.row_n[rr]) col_w[cc] = 1'b0;
  end
  assign bus.col_n = col_w;

  // Event monitor
  always @(negedge clk) begin
    run = keys[tgt] ? run + 1 : 0;
    if (resetn && bus.dval === 1'b1) begin
      evq.push_back(ev_t'{bus.gpi, bus.gpi_hold, cyc, run});
      n_chk++;
      assert (prev_dval === 1'b0) else begin
        n_fail++;
        $error("FAIL dval_back_to_back observed=%b expected=0", prev_dval);
      end
    end
    prev_dval = resetn ? bus.dval : 1'b0;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] row_drive(int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (r % 4));
  endfunction

  // One press: optional bounce, optional second key in the same row, held
  // for a short or long time (long = hold plus m repeat periods), optional
  // unrelated key pressed and released while the first one is captured.
  task automatic do_press(int r, int c, int c2, bit bounce, bit long_p, int m, bit distract);
    int         p, a, nexp, d;
    bit         got;
    logic [3:0] code;
    code = {r[1:0], c[1:0]};
    evq.delete();
    tgt = r*4 + c;
    if (bounce) begin
      for (int b = 0; b < 2; b++) begin
        keys[tgt] = 1'b1;
        tick($urandom_range(1, DEBOUNCE_CYC - 1));
        keys[tgt] = 1'b0;
        tick(2);
      end
    end
    keys[tgt] = 1'b1;
    if (c2 >= 0) keys[r*4+c2] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8*SCAN_DIV + 20 && !got; i++) begin
      tick(1);
      got = (evq.size() > 0);
    end
    check("accept_seen", 32'(got), 1);
    if (!got) begin
      keys = '0;
      tick(4*SCAN_DIV + 3*DEBOUNCE_CYC);
      return;
    end
    a = evq[0].cyc;
    check("accept_code", evq[0].code, code);
    check("accept_hold_lvl", evq[0].hold, 0);
    check("accept_stable", 32'(evq[0].run >= DEBOUNCE_CYC), 1);

    p = long_p ? HOLD_CYC + REPEAT_CYC*m + 4 : $urandom_range(3, HOLD_CYC - 6);
    if (distract) begin
      do d = $urandom_range(0, 15);
      while (d == tgt || (c2 >= 0 && d == r*4 + c2));
      tick(1);
      keys[d] = 1'b1;
      tick(p - 2);
      keys[d] = 1'b0;
      tick(1);
    end else begin
      tick(p);
    end
    check("hold_level", bus.gpi_hold, 32'(long_p));
    keys = '0;

    got = 1'b0;
    for (int i = 0; i < 3*DEBOUNCE_CYC + 6 && !got; i++) begin
      tick(1);
      got = (bus.row_n !== row_drive(r));
    end
    check("release_done", 32'(got), 1);
    check("row_after_release", bus.row_n, row_drive(r + 1));
    check("hold_cleared", bus.gpi_hold, 0);
    check("gpi_retained", bus.gpi, code);
    tick(2*SCAN_DIV);

    nexp = 1;
`ifdef KEYPAD_AUTOREPEAT_EN
    if (long_p) nexp += m + 1;
`else
    if (long_p) nexp += 1;
`endif
    check("event_count", evq.size(), nexp);
    for (int i = 1; i < evq.size() && i < nexp; i++) begin
      check("hold_ev_code", evq[i].code, code);
      check("hold_ev_flag", evq[i].hold, 1);
      check("hold_ev_time", evq[i].cyc - a, HOLD_CYC + REPEAT_CYC*(i-1));
    end
  endtask

  initial begin
    // Reset values
    resetn = 1'b0;
    tick(3);
    check("rst_row_n", bus.row_n, 4'b1110);
    check("rst_gpi", bus.gpi, 4'h0);
    check("rst_dval", bus.dval, 0);
    check("rst_hold", bus.gpi_hold, 0);

    // Idle scanning: row k/SCAN_DIV mod 4 after k cycles
    resetn = 1'b1;
    for (int k = 0; k < 8*SCAN_DIV; k++) begin
      check("idle_row_n", bus.row_n, row_drive(k / SCAN_DIV));
      if (k % SCAN_DIV == 0) begin
        check("idle_dval", bus.dval, 0);
        check("idle_gpi", bus.gpi, 4'h0);
      end
      tick(1);
    end

    // Directed cases
    do_press(2, 1, -1, 1'b0, 1'b0, 0, 1'b0);   // clean short press, code 9
    do_press(0, 3, -1, 1'b1, 1'b0, 0, 1'b0);   // bouncy press, code 3
    do_press(1, 0, -1, 1'b0, 1'b1, 2, 1'b0);   // long hold, code 4
    do_press(3, 0,  2, 1'b0, 1'b0, 0, 1'b0);   // two keys in a row, code C
    do_press(1, 2, -1, 1'b0, 1'b1, 1, 1'b1);   // hold with a distracting key

    // Randomized presses
    for (int it = 0; it < 12; it++) begin
      int r, c, c2;
      r  = $urandom_range(0, 3);
      c  = $urandom_range(0, 3);
      c2 = (c < 3 && $urandom_range(0, 2) == 0) ? $urandom_range(c + 1, 3) : -1;
      do_press(r, c, c2, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
               $urandom_range(0, 2), 1'(($urandom_range(0, 1))));
    end

    // Reset mid-press, before the earliest possible acceptance
    evq.delete();
    resetn = 1'b0;
    tick(2);
    tgt = 1;
    keys[tgt] = 1'b1;
    resetn = 1'b1;
    tick(SCAN_DIV + 1);
    resetn = 1'b0;
    tick(1);
    check("midrst_row_n", bus.row_n, 4'b1110);
    check("midrst_gpi", bus.gpi, 4'h0);
    check("midrst_dval", bus.dval, 0);
    check("midrst_hold", bus.gpi_hold, 0);
    keys = '0;
    tick(1);
    resetn = 1'b1;
    tick(1);
    check("midrst_first_row", bus.row_n, 4'b1110);
    tick(4*SCAN_DIV);
    check("midrst_no_event", evq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
